pix_downsample_2x2: RTL and testbench

- Streaming 2x2 box-filter down-sampler for the image processor datapath.
- Parametrised successor of the fixed down-sampling core: frame width, height and pixel width are parameters, and both sides of the stream use valid/ready handshakes.
- Takes raster-order pixels; emits one averaged pixel per 2x2 block, giving IMG_W/2 x IMG_H/2 output.
- Raises com_over when the frame is complete.

---
 rtl/pix_downsample_2x2.sv | 143 ++++++++++++++
 tb/tb_pix_downsample_2x2.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pix_downsample_2x2.sv
// pix_downsample_2x2: streaming 2x2 box-filter down-sampler.
// Raster-order pixels in, one averaged pixel per 2x2 block out, valid/ready on
// both sides. com_over pulses for one cycle when a frame has fully drained.
// Optional macro DS_ROUND_EN: round half up instead of truncating the average.
module pix_downsample_2x2 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             busy,
  output logic             com_over
);

  localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_N = IMG_W / 2;
  localparam int AW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] h_reg;
  logic [PIX_W:0]   lbuf [LB_N];

  logic             in_xfer;
  logic             out_xfer;
  logic             col_last;
  logic             row_last;
  logic             col_odd;
  logic             row_odd;
  logic [AW-1:0]    lb_addr;
  logic [PIX_W:0]   hsum;
  logic [PIX_W:0]   lb_rd;
  logic [PIX_W+1:0] total;
  logic [PIX_W+1:0] total_adj;

  // Handshakes: input accepted only in RUN and only when the output slot frees up
  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    busy     = (state != IDLE);
  end

  // Position decode and the horizontal/vertical sums
  always_comb begin
    col_last = (col == CW'(IMG_W - 1));
    row_last = (row == RW'(IMG_H - 1));
    col_odd  = col[0];
    row_odd  = row[0];
    lb_addr  = AW'(col >> 1);
    hsum     = {1'b0, h_reg} + {1'b0, in_pixel};
    lb_rd    = lbuf[lb_addr];
    total    = {1'b0, lb_rd} + {1'b0, hsum};
`ifdef DS_ROUND_EN
    total_adj = total + {{PIX_W{1'b0}}, 2'b10};
`else
    total_adj = total;
`endif
  end

  // Line buffer: even rows store horizontal pair sums for the odd row below.
  // No reset needed: every even row rewrites an entry before its odd row reads it.
  always_ff @(posedge clk) begin
    if (in_xfer && col_odd && !row_odd) begin
      lbuf[lb_addr] <= hsum;
    end
  end

  // Control FSM, counters, horizontal register and registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      h_reg     <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      com_over  <= 1'b0;
    end else begin
      com_over <= 1'b0;

      // A fresh result takes priority so a same-cycle transfer leaves no bubble
      if (in_xfer && col_odd && row_odd) begin
        out_valid <= 1'b1;
        out_pixel <= PIX_W'(total_adj >> 2);
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end

      if (in_xfer && !col_odd) begin
        h_reg <= in_pixel;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (in_xfer) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= DRAIN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Only the final block's result can be pending here
          if (out_xfer) begin
            state    <= IDLE;
            com_over <= 1'b1;
            col      <= '0;
            row      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_downsample_2x2.sv
// Directed bench for pix_downsample_2x2 on a 4x4, 8-bit frame.
// Expected averages come from a hand-filled block table; the rounding column
// is selected when DS_ROUND_EN is defined.
module tb_pix_downsample_2x2;

  localparam int PW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NOUT = NPIX / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pixel;
  logic          busy;
  logic          com_over;

  pix_downsample_2x2 #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .busy(busy), .com_over(com_over)
  );

  always #20 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // One 2x2 block: pixels p0 p1 (upper row), p2 p3 (lower row), both expectations
  typedef struct packed {
    logic [7:0] p0, p1, p2, p3;
    logic [7:0] et;  // truncated average
    logic [7:0] er;  // rounded average
  } blk_t;

  blk_t          tbl [8];
  logic [PW-1:0] fpix [NPIX];
  logic [PW-1:0] fexp [NOUT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},  in_ready,  0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_pixel"}, out_pixel, 0);
    chk({tag, " busy"},      busy,      0);
    chk({tag, " com_over"},  com_over,  0);
  endtask

  // Lay four table blocks out as a 4x4 raster frame
  task automatic build_from_table(input int base);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int b, q;
        b = base + (r / 2) * 2 + (c / 2);
        q = (r % 2) * 2 + (c % 2);
        case (q)
          0: fpix[r*W+c] = tbl[b].p0;
          1: fpix[r*W+c] = tbl[b].p1;
          2: fpix[r*W+c] = tbl[b].p2;
          default: fpix[r*W+c] = tbl[b].p3;
        endcase
      end
    end
    for (int k = 0; k < NOUT; k++) begin
`ifdef DS_ROUND_EN
      fexp[k] = tbl[base+k].er;
`else
      fexp[k] = tbl[base+k].et;
`endif
    end
  endtask

  task automatic build_flat(input logic [PW-1:0] v, input logic [PW-1:0] e);
    for (int i = 0; i < NPIX; i++) fpix[i] = v;
    for (int k = 0; k < NOUT; k++) fexp[k] = e;
  endtask

  // Streams one frame; bp stalls the first result for 5 cycles; abort_after>0
  // returns right after that many input transfers without finishing the frame.
  task automatic run_frame(input string tag, input bit bp, input int abort_after);
    int pi, oi, com_cnt, bp_left, cyc, tail;
    bit expect_com, in_x, out_x, aborted;
    pi = 0; oi = 0; com_cnt = 0; cyc = 0; tail = 0;
    bp_left = bp ? 5 : 0;
    expect_com = 0; aborted = 0;

    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);

    in_valid  = 1'b1;
    in_pixel  = fpix[0];
    out_ready = !bp;

    while (tail < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (com_over) begin
        com_cnt++;
        chk({tag, " busy at com_over"}, busy, 0);
        chk({tag, " com_over timing"}, expect_com, 1);
      end
      expect_com = 0;
      if (com_cnt > 0) begin
        tail++;
        if (out_valid) chk({tag, " no output after com_over"}, out_valid, 0);
      end
      if (bp_left > 0 && out_valid) begin
        chk({tag, " stall in_ready"}, in_ready, 0);
        chk({tag, " stall out_pixel"}, out_pixel, fexp[0]);
        bp_left--;
      end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        if (oi < NOUT) chk($sformatf("%s out[%0d]", tag, oi), out_pixel, fexp[oi]);
        else           chk({tag, " extra output"}, oi, NOUT);
        oi++;
        if (oi == NOUT) expect_com = 1;
      end
      if (in_x) pi++;

      @(posedge clk); #1;
      if (abort_after > 0 && pi >= abort_after) begin
        aborted = 1;
        break;
      end
      in_valid  = (pi < NPIX);
      in_pixel  = (pi < NPIX) ? fpix[pi] : '0;
      out_ready = !(bp && bp_left > 0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!aborted) begin
      if (cyc >= 400) chk({tag, " timeout"}, cyc, 0);
      chk({tag, " output count"}, oi, NOUT);
      chk({tag, " com_over count"}, com_cnt, 1);
    end
  endtask

  initial begin
    //            p0      p1      p2      p3      trunc   round
    tbl[0] = '{8'd1,   8'd2,   8'd3,   8'd4,   8'd2,   8'd3};
    tbl[1] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    tbl[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    tbl[4] = '{8'd0,   8'd0,   8'd0,   8'd1,   8'd0,   8'd0};
    tbl[5] = '{8'd0,   8'd0,   8'd1,   8'd1,   8'd0,   8'd1};
    tbl[6] = '{8'd255, 8'd0,   8'd255, 8'd0,   8'd127, 8'd128};
    tbl[7] = '{8'd10,  8'd20,  8'd30,  8'd41,  8'd25,  8'd25};

    // Reset hold
    #100;
    chk_reset_outputs("reset");
    #10 rst = 1'b1;

    // in_valid while idle must not be accepted
    in_valid = 1'b1;
    in_pixel = 8'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle in_ready", in_ready, 0);
      chk("idle busy", busy, 0);
    end
    in_valid = 1'b0;

    // Flat frame
    build_flat(8'd100, 8'd100);
    run_frame("flat100", 1'b0, 0);

    // Table-driven frames; second one also exercises back-pressure ordering
    for (int f = 0; f < 2; f++) begin
      build_from_table(f * 4);
      run_frame($sformatf("table%0d", f), f == 1, 0);
    end

    // Max value in every pixel
    build_flat(8'd255, 8'd255);
    run_frame("max255", 1'b0, 0);

    // Mid-frame reset after 6 transfers, then a clean frame
    build_flat(8'd200, 8'd200);
    run_frame("abort", 1'b0, 6);
    rst = 1'b0;
    #5;
    chk_reset_outputs("midreset");
    @(posedge clk); #5;
    rst = 1'b1;
    build_flat(8'd100, 8'd100);
    run_frame("after_reset", 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
